sample_fifo: RTL and testbench

//   Single-clock first-word-fall-through FIFO for 16-bit audio sample packets.

---
 rtl/sample_fifo.sv | 89 ++++++++
 tb/tb_sample_fifo.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sample_fifo.sv
// Single-clock first-word-fall-through FIFO for 16-bit audio sample packets.
// Provides valid/ready backpressure and reports occupancy, peak occupancy and sticky overflow.
module sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   peak,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    next_count;
    logic             push;
    logic             pop;

    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Head is forced to zero while empty so stale storage never shows on out_data.
    assign out_data  = empty ? '0 : mem[rd_ptr];

    always_comb begin
        next_count = count;
        if (push && !pop) begin
            next_count = count + 1'b1;
        end else if (pop && !push) begin
            next_count = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            peak     <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            peak     <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= next_count;
            if (next_count > peak) begin
                peak <= next_count;
            end
            if (in_valid && full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sample_fifo.sv
// Directed self-checking bench for sample_fifo: fill/drain, full/overflow,
// streaming wrap-around, pop-while-full, async reset and sync clear.
module tb_sample_fifo;

    logic        clk;
    logic        reset;
    logic        clear;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  count;
    logic [6:0]  peak;
    logic        full;
    logic        empty;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    sample_fifo #(.WIDTH(16), .DEPTH(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .peak      (peak),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] seq4 [4];

    initial begin
        seq4[0] = 16'hAAAA; seq4[1] = 16'hBBBB; seq4[2] = 16'hCCCC; seq4[3] = 16'hDDDD;
        reset = 1'b1; clear = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;

        // reset state
        #3;
        chk("rst_count", count, 0);
        chk("rst_peak", peak, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_overflow", overflow, 0);
        @(negedge clk);
        reset = 1'b0;

        // 1: push four with out_ready low
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = seq4[i];
            tick();
            if (i == 0) begin
                chk("t1_latency_valid", out_valid, 1);
                chk("t1_latency_data", out_data, 16'hAAAA);
            end
        end
        in_valid = 1'b0;
        chk("t1_count", count, 4);
        chk("t1_empty", empty, 0);
        chk("t1_head", out_data, 16'hAAAA);
        chk("t1_peak", peak, 4);

        // 2: pop four in order
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_order", out_data, seq4[i]);
            tick();
        end
        out_ready = 1'b0;
        chk("t2_empty", empty, 1);
        chk("t2_count", count, 0);
        chk("t2_peak", peak, 4);
        chk("t2_out_valid", out_valid, 0);

        // 3: fill to DEPTH, then offer DEAD while full
        for (int i = 0; i < 64; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h1000 + 16'(i);
            tick();
        end
        chk("t3_full", full, 1);
        chk("t3_in_ready", in_ready, 0);
        chk("t3_count", count, 64);
        chk("t3_no_ovf_yet", overflow, 0);
        in_data = 16'hDEAD;
        tick();
        chk("t3_overflow", overflow, 1);
        chk("t3_count_hold", count, 64);
        chk("t3_peak", peak, 64);
        chk("t3_head", out_data, 16'h1000);

        // 5: in_valid and out_ready together while full -> pop only
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t5_count", count, 63);
        chk("t5_in_ready", in_ready, 1);
        chk("t5_full", full, 0);
        for (int i = 1; i < 64; i++) begin
            chk("t3_drain_order", out_data, 16'h1000 + 16'(i));
            tick();
        end
        out_ready = 1'b0;
        chk("t3_drained_empty", empty, 1);
        chk("t3_drained_data", out_data, 0);
        chk("t3_overflow_sticky", overflow, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_overflow", overflow, 0);
        chk("clr_peak", peak, 0);

        // 4: stream 100 packets with push and pop each cycle
        in_valid = 1'b1;
        in_data  = 16'hA000;
        tick();
        out_ready = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            in_data = 16'hA000 + 16'(i);
            chk("t4_order", out_data, 16'hA000 + 16'(i - 1));
            tick();
            chk("t4_count", count, 1);
        end
        in_valid = 1'b0;
        chk("t4_last", out_data, 16'hA064);
        tick();
        out_ready = 1'b0;
        chk("t4_empty", empty, 1);
        chk("t4_peak", peak, 1);

        // 6a: async reset mid-burst
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 16'h5000 + 16'(i);
            tick();
        end
        chk("t6_count10", count, 10);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_count", count, 0);
        chk("t6_async_peak", peak, 0);
        chk("t6_async_out_valid", out_valid, 0);
        chk("t6_async_out_data", out_data, 0);
        in_valid = 1'b0;
        tick();
        reset = 1'b0;
        chk("t6_reset_hold", count, 0);

        // 6b: clear wins over push+pop, including a same-cycle overflow
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 16'h6000 + 16'(i);
            tick();
        end
        chk("t6_count5", count, 5);
        out_ready = 1'b1;
        clear     = 1'b1;
        tick();
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("t6_clr_count", count, 0);
        chk("t6_clr_peak", peak, 0);
        chk("t6_clr_overflow", overflow, 0);
        chk("t6_clr_out_valid", out_valid, 0);

        // clear with overflow condition in the same cycle
        in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            in_data = 16'h7000 + 16'(i);
            tick();
        end
        chk("t6_refull", full, 1);
        clear = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("t6_clr_ovf_same_cycle", overflow, 0);
        chk("t6_clr_full_count", count, 0);

        // push after clear starts from a clean state
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        tick();
        in_valid = 1'b0;
        chk("post_clr_data", out_data, 16'hBEEF);
        chk("post_clr_count", count, 1);
        chk("post_clr_peak", peak, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
